// File: rtl/ones_count_pkg.sv
// Shared types and constants for the ones counter / expander pair.
// Holds the FSM state type and the saturated thermometer helper.
package ones_count_pkg;

  localparam int OC_WIDTH = 15;
  localparam int OC_CW    = 4;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  function automatic logic [OC_WIDTH-1:0] thermo_of(
    input logic [OC_CW-1:0] n
  );
    logic [OC_WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < OC_WIDTH; i++)
      w[i] = (i < int'(n));
    return w;
  endfunction

endpackage

// File: rtl/ones_count_expander_if.sv
// Count request and serial bit stream handshake bundle.
// master = upstream/downstream side, slave = expander.
import ones_count_pkg::*;

interface ones_count_expander_if #(
  parameter int CW = OC_CW
);
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_count;
  logic          out_bit;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;

  modport master (
    output in_valid, in_count, out_ready,
    input  in_ready, out_bit, out_valid, out_last
  );

  modport slave (
    input  in_valid, in_count, out_ready,
    output in_ready, out_bit, out_valid, out_last
  );
endinterface

// File: rtl/ones_count_expander_thermo_gen.sv
// Count to saturated thermometer frame plus overflow flag.
// Frame carries a trailing n[0] parity bit when FL > WIDTH.
import ones_count_pkg::*;

module thermo_gen #(
  parameter int WIDTH = OC_WIDTH,
  parameter int CW    = OC_CW,
  parameter int FL    = OC_WIDTH
) (
  input  logic [CW-1:0] count,
  output logic [FL-1:0] frame,
  output logic          ovf
);

  logic [CW-1:0] n;

  // saturate the count, then expand it into LSB-first ones
  always_comb begin
    ovf   = int'(count) > WIDTH;
    n     = ovf ? CW'(WIDTH) : count;
    frame = '0;
    for (int i = 0; i < WIDTH; i++)
      frame[i] = (i < int'(n));
    if (FL > WIDTH)
      frame[FL-1] = n[0];
  end

endmodule

// File: rtl/ones_count_expander.sv
// Regenerates a thermometer word from a ones-count and streams it LSB-first.
// Define ONES_COUNT_EXPANDER_PARITY_EN to append an n[0] parity bit per frame.
import ones_count_pkg::*;

module ones_count_expander #(
  parameter int WIDTH = OC_WIDTH,
  parameter int CW    = OC_CW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ones_count_expander_if.slave io,
  output logic [WIDTH-1:0]     thermo,
  output logic                 sat
);

`ifdef ONES_COUNT_EXPANDER_PARITY_EN
  localparam int FL = WIDTH + 1;
  localparam int IW = $clog2(WIDTH + 1);
`else
  localparam int FL = WIDTH;
  localparam int IW = CW;
`endif

  localparam logic [IW-1:0] LAST = IW'(FL - 1);

  state_t        state;
  logic [FL-1:0] shift;
  logic [IW-1:0] idx;
  logic [FL-1:0] frame;
  logic          ovf;

  thermo_gen #(
    .WIDTH (WIDTH),
    .CW    (CW),
    .FL    (FL)
  ) u_gen (
    .count (io.in_count),
    .frame (frame),
    .ovf   (ovf)
  );

  // accept a count in IDLE, then shift the frame out under out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shift        <= '0;
      idx          <= '0;
      thermo       <= '0;
      sat          <= 1'b0;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.out_last  <= 1'b0;
      io.out_bit   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.in_valid) begin
            state        <= SHIFT;
            thermo       <= frame[WIDTH-1:0];
            shift        <= frame;
            idx          <= '0;
            sat          <= sat | ovf;
            io.in_ready  <= 1'b0;
            io.out_valid <= 1'b1;
            io.out_bit   <= frame[0];
            io.out_last  <= 1'b0;
          end
        end
        SHIFT: begin
          if (io.out_ready) begin
            if (idx == LAST) begin
              state        <= IDLE;
              io.in_ready  <= 1'b1;
              io.out_valid <= 1'b0;
              io.out_last  <= 1'b0;
              io.out_bit   <= 1'b0;
            end else begin
              shift       <= shift >> 1;
              idx         <= idx + 1'b1;
              io.out_bit  <= shift[1];
              io.out_last <= (idx + 1'b1) == LAST;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ones_count_expander.sv
// Self-checking bench: queue-based frame model plus directed literal checks.
// Covers default and WIDTH=10 instances, with or without parity.
module tb_ones_count_expander;
  import ones_count_pkg::*;

`ifdef ONES_COUNT_EXPANDER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL0 = 15 + PAR;
  localparam int FL1 = 10 + PAR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [14:0] th0;
  logic [9:0] th1;
  logic sat0, sat1;

  ones_count_expander_if #(.CW(4)) i0 ();
  ones_count_expander_if #(.CW(4)) i1 ();

  ones_count_expander u0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .io     (i0.slave),
    .thermo (th0),
    .sat    (sat0)
  );

  ones_count_expander #(.WIDTH(10)) u1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .io     (i1.slave),
    .thermo (th1),
    .sat    (sat1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // model of u0: pending frame bits in a queue
  bit q[$];
  logic [14:0] m_th;
  bit m_sat;
  int m_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_th = '0;
      m_sat = 1'b0;
    end else if (q.size() == 0) begin
      if (i0.in_valid) begin
        m_n = (int'(i0.in_count) > 15) ? 15 : int'(i0.in_count);
        if (int'(i0.in_count) > 15) m_sat = 1'b1;
        m_th = 15'((32'd1 << m_n) - 1);
        for (int k = 0; k < 15; k++) q.push_back(k < m_n);
        if (PAR == 1) q.push_back(m_n % 2 == 1);
      end
    end else if (i0.out_ready) begin
      void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", i0.in_ready, q.size() == 0);
      chk("out_valid", i0.out_valid, q.size() != 0);
      chk("out_last", i0.out_last, q.size() == 1);
      if (q.size() != 0) chk("out_bit", i0.out_bit, q[0]);
      chk("thermo", th0, m_th);
      chk("sat", sat0, m_sat);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int d, input logic [3:0] c);
    int t = 0;
    while (!(d == 0 ? i0.in_ready : i1.in_ready) && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) chk("req_timeout", 1, 0);
    if (d == 0) begin
      i0.in_valid = 1'b1;
      i0.in_count = c;
    end else begin
      i1.in_valid = 1'b1;
      i1.in_count = c;
    end
    tick();
    i0.in_valid = 1'b0;
    i1.in_valid = 1'b0;
  endtask

  task automatic run(input int d, output int len,
                     output logic [31:0] bits, output int lastpos);
    len = 0;
    bits = '0;
    lastpos = -1;
    while ((d == 0 ? i0.out_valid : i1.out_valid) && len < 32) begin
      bits[len] = (d == 0) ? i0.out_bit : i1.out_bit;
      if (d == 0 ? i0.out_last : i1.out_last) lastpos = len;
      len++;
      tick();
    end
  endtask

  int len, lastpos, cyc;
  logic [31:0] bits;

  initial begin
    i0.in_valid = 1'b0; i0.in_count = '0; i0.out_ready = 1'b1;
    i1.in_valid = 1'b0; i1.in_count = '0; i1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", i0.in_ready, 1);
    chk("rst_out_valid", i0.out_valid, 0);
    chk("rst_out_last", i0.out_last, 0);
    chk("rst_out_bit", i0.out_bit, 0);
    chk("rst_thermo", th0, 0);
    chk("rst_sat", sat0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // zero count
    req(0, 4'd0);
    chk("t0_valid", i0.out_valid, 1);
    chk("t0_thermo", th0, 15'h0000);
    run(0, len, bits, lastpos);
    chk("t0_len", len, FL0);
    chk("t0_bits", bits, 32'h0);
    chk("t0_lastpos", lastpos, FL0 - 1);
    chk("t0_ready_again", i0.in_ready, 1);

    // five ones
    req(0, 4'd5);
    chk("t5_valid", i0.out_valid, 1);
    chk("t5_thermo", th0, 15'h001F);
    run(0, len, bits, lastpos);
    chk("t5_bits", bits, PAR == 1 ? 32'h801F : 32'h001F);
    chk("t5_lastpos", lastpos, FL0 - 1);

    // six ones: parity bit clear
    req(0, 4'd6);
    run(0, len, bits, lastpos);
    chk("t6_bits", bits, 32'h003F);
    chk("t6_len", len, FL0);

    // full count with out_ready toggling
    req(0, 4'd15);
    chk("t15_thermo", th0, 15'h7FFF);
    cyc = 0;
    while (i0.out_valid && cyc < 80) begin
      cyc++;
      tick();
      i0.out_ready = ~i0.out_ready;
    end
    chk("t15_span", cyc, 2 * FL0 - 1);
    i0.out_ready = 1'b1;
    tick();

    // reset in the middle of a frame
    req(0, 4'd7);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", i0.out_valid, 0);
    chk("ar_thermo", th0, 0);
    chk("ar_in_ready", i0.in_ready, 1);
    chk("ar_out_last", i0.out_last, 0);
    tick();
    rst_n = 1'b1;
    tick();
    req(0, 4'd2);
    run(0, len, bits, lastpos);
    chk("ar_bits", bits, 32'h3);
    chk("ar_len", len, FL0);

    // narrow instance saturates
    req(1, 4'd12);
    chk("w10_thermo", th1, 10'h3FF);
    chk("w10_sat", sat1, 1);
    run(1, len, bits, lastpos);
    chk("w10_bits", bits, 32'h3FF);
    chk("w10_len", len, FL1);
    chk("w10_lastpos", lastpos, FL1 - 1);
    req(1, 4'd3);
    chk("w10_thermo3", th1, 10'h007);
    chk("w10_sat_sticky", sat1, 1);
    run(1, len, bits, lastpos);
    chk("w10_bits3", bits, PAR == 1 ? 32'h407 : 32'h007);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      i0.in_valid = 1'($urandom_range(0, 1));
      i0.in_count = 4'($urandom_range(0, 15));
      i0.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    i0.in_valid = 1'b0;
    i0.out_ready = 1'b1;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
